vedic_seq_multiplier: RTL and testbench

VEDIC_SEQ_MULTIPLIER -- requirements
Module: vedic_seq_multiplier

---
 rtl/vedic_seq_multiplier.sv | 156 +++++++++++++++
 tb/tb_vedic_seq_multiplier.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vedic_seq_multiplier.sv
// rtl/vedic_seq_multiplier.sv - sequential chunked multiplier built on a Vedic (Urdhva-Tiryagbhyam) sub-multiplier
module vedic_cell2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    logic t0, t1, t2, c1, t3;

    assign t0   = x[1] & y[0];
    assign t1   = x[0] & y[1];
    assign t2   = x[1] & y[1];
    assign c1   = t0 & t1;
    assign t3   = t2 & c1;
    assign p[0] = x[0] & y[0];
    assign p[1] = t0 ^ t1;
    assign p[2] = t2 ^ c1;
    assign p[3] = t3;
endmodule

module vedic_seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);
    localparam int N  = WIDTH / CHUNK;
    localparam int M  = CHUNK / 2;
    localparam int PW = 2 * CHUNK;
    localparam int RW = 2 * WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t            state, state_nxt;
    logic              started;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic              neg;
    logic [RW-1:0]     acc;
    logic [RW-1:0]     prod_q;
    logic              prod_v;
    logic              issued_all;
    logic [IW-1:0]     cnt_i, cnt_j;

    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic [3:0]        cell_p [M*M];
    logic [PW-1:0]     sub;
    logic [RW-1:0]     sub_shifted;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic              accept, issuing;

    assign in_ready  = started && (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign issuing   = (state == RUN) && !issued_all;

    // -MIN has no positive WIDTH-bit twin; -a wraps to the same bit pattern, read as unsigned 2^(WIDTH-1)
    assign a_abs = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_abs = (signed_mode && b[WIDTH-1]) ? -b : b;

    assign a_chunk = a_mag[int'(cnt_i)*CHUNK +: CHUNK];
    assign b_chunk = b_mag[int'(cnt_j)*CHUNK +: CHUNK];

    for (genvar p = 0; p < M; p++) begin : g_row
        for (genvar q = 0; q < M; q++) begin : g_col
            vedic_cell2 u_cell (
                .x (a_chunk[2*p +: 2]),
                .y (b_chunk[2*q +: 2]),
                .p (cell_p[p*M+q])
            );
        end
    end

    // Vertical-and-crosswise: every 2x2 cell lands in base-4 column p+q
    always_comb begin
        sub = '0;
        for (int p = 0; p < M; p++) begin
            for (int q = 0; q < M; q++) begin
                sub = sub + (PW'(cell_p[p*M+q]) << (2*(p+q)));
            end
        end
    end

    assign sub_shifted = RW'(sub) << (CHUNK*(int'(cnt_i) + int'(cnt_j)));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)     state_nxt = RUN;
            RUN:  if (issued_all) state_nxt = SIGN;
            SIGN:                 state_nxt = DONE;
            DONE: if (out_ready)  state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            started <= 1'b0;
        end else begin
            state <= state_nxt;
            started <= 1'b1;
        end
    end

    // Sub-products are registered before accumulation so the Vedic tree and the wide adder sit in separate stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mag      <= '0;
            b_mag      <= '0;
            neg        <= 1'b0;
            acc        <= '0;
            prod_q     <= '0;
            prod_v     <= 1'b0;
            issued_all <= 1'b0;
            cnt_i      <= '0;
            cnt_j      <= '0;
            result     <= '0;
        end else begin
            if (accept) begin
                a_mag      <= a_abs;
                b_mag      <= b_abs;
                neg        <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                acc        <= '0;
                prod_v     <= 1'b0;
                issued_all <= 1'b0;
                cnt_i      <= '0;
                cnt_j      <= '0;
            end else if (state == RUN) begin
                prod_v <= issuing;
                if (prod_v) acc <= acc + prod_q;
                if (issuing) begin
                    prod_q <= sub_shifted;
                    if (cnt_j == IW'(N-1)) begin
                        cnt_j <= '0;
                        if (cnt_i == IW'(N-1)) issued_all <= 1'b1;
                        else                   cnt_i <= cnt_i + 1'b1;
                    end else begin
                        cnt_j <= cnt_j + 1'b1;
                    end
                end
            end else if (state == SIGN) begin
                result <= neg ? -acc : acc;
            end
        end
    end
endmodule

// File: tb/tb_vedic_seq_multiplier.sv
// tb/tb_vedic_seq_multiplier.sv - scoreboard bench for vedic_seq_multiplier
module tb_vedic_seq_multiplier;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    vedic_seq_multiplier #(.WIDTH(W), .CHUNK(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h required %h", name, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %h required none", result);
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input string name, input logic sm, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [63:0] expv,
                          input bit scramble, input int hold);
        int lat;
        bit got_ready;
        logic [63:0] rsave;
        @(posedge clk);
        #2;
        a = aa; b = bb; signed_mode = sm; in_valid = 1'b1;
        out_ready = (hold == 0);
        got_ready = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got_ready = 1'b1;
                break;
            end
        end
        if (!got_ready) begin
            check({"in_ready_wait_", name}, 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(expv);
        #2;
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
            if (scramble) begin
                a = $urandom;
                b = $urandom;
                signed_mode = 1'($urandom);
                in_valid = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        check({"latency_", name}, 64'(lat), 64'd18);
        if (lat == 0) begin
            out_ready = 1'b1;
            return;
        end
        if (hold > 0) begin
            rsave = result;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({"hold_valid_", name}, 64'(out_valid), 64'd1);
                check({"hold_result_", name}, result, rsave);
                check({"hold_in_ready_", name}, 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            #2;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({"in_ready_after_", name}, 64'(in_ready), 64'd1);
        check({"out_valid_after_", name}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #12;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", result, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_first_edge", 64'(in_ready), 64'd1);

        run_op("u_max",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, 0);
        run_op("s_m1x1",    1'b1, 32'hFFFFFFFF, 32'h00000001, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0);
        run_op("u_m1x1",    1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF, 1'b0, 0);
        run_op("s_minsq",   1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, 0);
        run_op("s_minx1",   1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000, 1'b0, 0);
        run_op("s_n3x5",    1'b1, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFFFFFFFFF1, 1'b0, 0);
        run_op("s_n7xn6",   1'b1, 32'hFFFFFFF9, 32'hFFFFFFFA, 64'h000000000000002A, 1'b0, 0);
        run_op("u_zero",    1'b0, 32'h00000000, 32'hDEADBEEF, 64'h0000000000000000, 1'b0, 0);
        run_op("u_2p16sq",  1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000, 1'b0, 0);
        run_op("u_scramble",1'b0, 32'd1234,     32'd5678,     64'h00000000006AE9BC, 1'b1, 5);

        @(posedge clk);
        #2;
        a = 32'h00001234; b = 32'h00005678; signed_mode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        check("rst_test_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", 64'(in_ready), 64'd1);
        check("rst_release_valid", 64'(out_valid), 64'd0);

        run_op("u_ffffsq",  1'b0, 32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001, 1'b0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
